// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Operands are widened to WIDTH+1 bits so one datapath serves signed and unsigned modes.
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic             r_signed;
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH:0]   r_q;
  logic             r_qm1;
  logic [CW-1:0]    r_count;

  logic [WIDTH+1:0]   w_m;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_zNext;

  // The accumulator carries one guard bit beyond the WIDTH+1 operand width so
  // subtracting the widened multiplicand can never wrap.
  assign w_m     = {{2{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_zNext = {r_acc[WIDTH-2:0], r_q};

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m;
      2'b10:   w_sum = r_acc - w_m;
      default: w_sum = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      z         <= '0;
      r_a       <= '0;
      r_signed  <= 1'b0;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_signed <= signed_mode;
            r_q      <= {signed_mode & b[WIDTH-1], b};
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_count  <= '0;
            r_state  <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          // The count reaching LAST means all WIDTH+1 iterations are done.
          if (r_count == LAST) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            z         <= w_zNext;
          end else begin
            r_acc   <= {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
            r_q     <= {w_sum[0], r_q[WIDTH:1]};
            r_qm1   <= r_q[0];
            r_count <= r_count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operand pair and mode presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  multiplicand.
REQ-007 Port: b  input  WIDTH  multiplier.
REQ-008 Port: signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 Port: out_valid  output  1  product z is valid.
REQ-010 Port: out_ready  input  1  consumer accepts z.
REQ-011 Port: z  output  2*WIDTH  product; two's-complement when signed_mode was 1.
REQ-012 Port: busy  output  1  high in CALC or DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 Accept: in_valid=1 in IDLE at edge T SHALL register a, b and signed_mode, and SHALL move the FSM to CALC.
REQ-016 Operands SHALL be extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0.
REQ-017 CALC SHALL run radix-2 Booth recoding for exactly WIDTH+1 iterations, one per cycle, using an iteration counter of ceil(log2(WIDTH+2)) bits.
REQ-018 Per-iteration Booth pair {q0,q-1}: 01 adds M, 10 subtracts M, 00/11 do nothing, then arithmetic right shift of {acc,q,q-1}.
REQ-019 After the last iteration the FSM SHALL enter DONE, and out_valid SHALL be asserted from edge T+WIDTH+2.
REQ-020 z SHALL equal the exact product truncated to its low 2*WIDTH bits; this SHALL be lossless for all operand pairs in both modes.
REQ-021 z and out_valid SHALL hold stable in DONE until out_valid=1 and out_ready=1 at an edge; that edge SHALL return the FSM to IDLE.
REQ-022 No combinational path from out_ready to in_ready: a new accept SHALL occur no earlier than the edge after the output handshake.
REQ-023 Input changes on a, b and signed_mode during CALC or DONE SHALL NOT affect the result in flight.
REQ-024 in_valid=1 while not in IDLE SHALL be ignored; no queueing, no error flag.
REQ-025 z SHALL retain the last product after returning to IDLE; out_valid SHALL be 0 outside DONE.
REQ-026 Corner operands: a or b equal to the most negative value (signed) or all-ones (unsigned) SHALL be handled by the WIDTH+1-bit extension and SHALL NOT overflow the accumulator.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, busy=0, z=0, iteration counter=0, operand registers=0, independent of clk.
REQ-029 Reset asserted mid-CALC or in DONE SHALL discard the operation; the first accept after release SHALL produce a correct product.
REQ-030 Deassertion of rst_n SHALL take effect at the next clk edge; in_valid sampled at that edge SHALL be accepted.

Verification (WIDTH=8 unless noted)
REQ-031 Signed basic: a=10, b=2 and a=-10, b=2 -> z=0x0014 and z=0xFFEC, out_valid at accept+10 edges.
REQ-032 Signed corners: (-12,-21) -> 0x00FC; (-128,-128) -> 0x4000; (-128,127) -> 0xC080; (-3,-2) -> 0x0006.
REQ-033 Unsigned mode: a=255, b=255, signed_mode=0 -> z=0xFE01; a=128, b=2 -> 0x0100.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z stable, in_ready=0, a second in_valid ignored; release -> in_ready=1 the next cycle.
REQ-035 Reset mid-CALC at iteration 4 -> all outputs reset at once; a following (-5,-5) -> 0x0019.
REQ-036 Parameter sweep: WIDTH=4, 16 and 32 with random signed and unsigned operands against a reference model -> all match; latency = WIDTH+2.
